// File: rtl/pipe_pkg.sv
// Shared fetch/decode pipeline types and constants.
// The packet struct fixes the field order {instr, pc, pcplus4} used by the queue storage.
package pipe_pkg;

  localparam int          PIPE_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PIPE_W-1:0] instr;
    logic [PIPE_W-1:0] pc;
    logic [PIPE_W-1:0] pcplus4;
  } fd_packet_t;

  // Helper that packs one fetch packet in the canonical field order.
  function automatic fd_packet_t make_packet(input logic [PIPE_W-1:0] instr,
                                             input logic [PIPE_W-1:0] pc,
                                             input logic [PIPE_W-1:0] pcplus4);
    fd_packet_t p;
    p.instr   = instr;
    p.pc      = pc;
    p.pcplus4 = pcplus4;
    return p;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_ram.sv
// Storage array for the fetch/decode queue: one synchronous write port, one asynchronous
// read port, no reset (contents are meaningless until written).
module fdq_ram #(
  parameter int DEPTH = 4,
  parameter int DW    = 96
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry fall-through FIFO of {instr, pc, pc+4} packets between Fetch and Decode.
// Presents a NOP bubble when empty; flush empties the queue in one cycle.
module fetch_decode_queue
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  input  logic                       pop_ready,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           InstrD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DW    = 3 * WIDTH;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic          push, pop, wr_en;
  logic [DW-1:0] wr_data, rd_data;

  // Handshake: a transfer happens on a side only in a cycle where both its valid and
  // ready are high at the rising edge; push_ready = !full, pop_valid = !empty, and
  // neither ready depends combinationally on the other side (no bypass in either way).
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push       = push_valid & push_ready;
  assign pop        = pop_ready & pop_valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en = push;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_data = {InstrF, PCF, PCPlus4F};

  fdq_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Empty queue shows a bubble so Decode never sees stale storage.
  always_comb begin
    InstrD   = WIDTH'(NOP_INSTR);
    PCD      = '0;
    PCPlus4D = '0;
    if (pop_valid) begin
      InstrD   = rd_data[3*WIDTH-1:2*WIDTH];
      PCD      = rd_data[2*WIDTH-1:WIDTH];
      PCPlus4D = rd_data[WIDTH-1:0];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: a queue-of-packets reference model updated at
// each rising edge, checked against the DUT outputs on every falling edge.
module tb_fetch_decode_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, push_valid, pop_ready;
  logic          push_ready, pop_valid;
  logic [W-1:0]  InstrF, PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [3*W-1:0] exp_q[$];

  fetch_decode_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .count      (count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Occupancy before the edge decides both acceptance and whether a pop happens.
  always @(posedge clk) begin
    if (rst === 1'b1 || flush === 1'b1) begin
      exp_q.delete();
    end else begin
      int  sz;
      bit  do_push, do_pop;
      sz      = exp_q.size();
      do_push = (push_valid === 1'b1) && (sz < DEPTH);
      do_pop  = (pop_ready === 1'b1) && (sz > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({InstrF, PCF, PCPlus4F});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_count", W'(count), W'(exp_q.size()));
      chk("mon_pop_valid", W'(pop_valid), W'(exp_q.size() != 0));
      chk("mon_push_ready", W'(push_ready), W'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) begin
        logic [3*W-1:0] h;
        h = exp_q[0];
        chk("mon_instr", InstrD, h[3*W-1:2*W]);
        chk("mon_pc", PCD, h[2*W-1:W]);
        chk("mon_pc4", PCPlus4D, h[W-1:0]);
      end else begin
        chk("mon_nop", InstrD, NOP);
        chk("mon_pc_zero", PCD, '0);
        chk("mon_pc4_zero", PCPlus4D, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit r, input bit f, input bit pv, input logic [W-1:0] pc,
                       input bit pr);
    rst        = r;
    flush      = f;
    push_valid = pv;
    InstrF     = $urandom;
    PCF        = pc;
    PCPlus4F   = pc + 32'd4;
    pop_ready  = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] pc);
    cycle(0, 0, 1, pc, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 32'h0, 0);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_count"}, W'(count), '0);
    chk({tag, "_pop_valid"}, W'(pop_valid), '0);
    chk({tag, "_push_ready"}, W'(push_ready), 1);
    chk({tag, "_instr"}, InstrD, NOP);
    chk({tag, "_pc"}, PCD, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    InstrF = '0; PCF = '0; PCPlus4F = '0;

    // 1: reset
    cycle(1, 0, 0, 32'h0, 0);
    cycle(1, 0, 0, 32'h0, 0);
    check_empty("t1");
    mon_en = 1'b1;

    // 2: fill, fifth push refused
    for (int i = 0; i < 4; i++) push_one(32'(i * 4));
    chk("t2_count", W'(count), 4);
    chk("t2_push_ready", W'(push_ready), 0);
    push_one(32'h10);
    chk("t2_count_hold", W'(count), 4);
    chk("t2_pcd_hold", PCD, 32'h0);

    // 3: drain in order
    for (int i = 0; i < 4; i++) begin
      chk("t3_pcd", PCD, 32'(i * 4));
      cycle(0, 0, 0, 32'h0, 1);
    end
    chk("t3_pop_valid", W'(pop_valid), 0);
    chk("t3_instr_nop", InstrD, NOP);

    // 4: steady push+pop at count=1 across pointer wraps
    push_one(32'h100);
    for (int i = 0; i < 10; i++) begin
      chk("t4_pcd", PCD, 32'h100 + 32'(i * 4));
      cycle(0, 0, 1, 32'h104 + 32'(i * 4), 1);
      chk("t4_count", W'(count), 1);
    end
    cycle(0, 0, 0, 32'h0, 1);

    // 5: flush beats a same-cycle push
    for (int i = 0; i < 3; i++) push_one(32'h200 + 32'(i * 4));
    chk("t5_count3", W'(count), 3);
    cycle(0, 1, 1, 32'hBAD0, 1);
    chk("t5_count", W'(count), 0);
    chk("t5_pop_valid", W'(pop_valid), 0);
    chk("t5_instr_nop", InstrD, NOP);
    idle();
    push_one(32'h240);
    chk("t5_new_head", PCD, 32'h240);
    cycle(0, 0, 0, 32'h0, 1);

    // 6: reset mid-stream
    push_one(32'h280);
    push_one(32'h284);
    chk("t6_count2", W'(count), 2);
    cycle(1, 0, 0, 32'h0, 0);
    check_empty("t6");
    push_one(32'h300);
    chk("t6_head", PCD, 32'h300);
    chk("t6_pc4", PCPlus4D, 32'h304);

    // 7: randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0);
    end

    idle();
    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
